// File: rtl/wiscsc15_pkg.sv
// Shared WISC-SC15 fetch types: HLT opcode, fetch FSM encodings, default widths, fetch entry.
package wiscsc15_pkg;

  localparam int IFQ_ADDR_W  = 16;
  localparam int IFQ_INSTR_W = 16;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    IFQ_IDLE   = 2'd0,
    IFQ_WAIT   = 2'd1,
    IFQ_DROP   = 2'd2,
    IFQ_HALTED = 2'd3
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0]  pc;
    logic [IFQ_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with registered storage; head is readable one cycle after push.
// clear has priority over push and pop; the caller never pushes when full or pops when empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [OCC_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat  = mem_q[rd_q];
  assign occupancy = cnt_q;
  assign full      = (cnt_q == OCC_W'(DEPTH));
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// WISC-SC15 fetch stage: one outstanding imem request, fetched words queued for decode.
// Define IFQ_BYPASS_EN to forward an ack straight to decode when the queue is empty.
import wiscsc15_pkg::*;

module ifetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                INSTR_W  = IFQ_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   im_req,
  output logic [ADDR_W-1:0]      im_addr,
  input  logic                   im_ack,
  input  logic [INSTR_W-1:0]     im_instr,
  output logic                   dec_valid,
  output logic [INSTR_W-1:0]     dec_instr,
  output logic [ADDR_W-1:0]      dec_pc,
  input  logic                   dec_ready,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int E_W   = ADDR_W + INSTR_W;

  ifq_state_e          state_q;
  logic [ADDR_W-1:0]   fetch_pc_q, im_addr_q;
  logic                im_req_q, halted_q;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [E_W-1:0]      head;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      occ_sum;
  logic                ack_wait, is_hlt, bypass, can_issue;

  assign ack_wait = (state_q == IFQ_WAIT) && im_ack;
  assign is_hlt   = (im_instr[INSTR_W-1 -: 4] == HLT_OPCODE);

`ifdef IFQ_BYPASS_EN
  assign bypass = ack_wait && !redirect && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a slot.
  assign fifo_push = ack_wait && !redirect && !(bypass && dec_ready);
  assign fifo_pop  = !fifo_empty && dec_ready;

  // Conservative issue check: a pop this cycle still counts against free space.
  assign occ_sum   = {1'b0, occ} + (OCC_W+1)'(fifo_pop);
  assign can_issue = !fifo_full && (occ_sum < (OCC_W+1)'(DEPTH));

  ifq_fifo #(.DEPTH(DEPTH), .W(E_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (fifo_push),
    .push_dat  ({fetch_pc_q, im_instr}),
    .pop       (fifo_pop),
    .head_dat  (head),
    .occupancy (occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IFQ_IDLE;
      fetch_pc_q <= RESET_PC;
      im_addr_q  <= RESET_PC;
      im_req_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        halted_q   <= 1'b0;
      end
      unique case (state_q)
        IFQ_IDLE: begin
          if (!redirect && can_issue) begin
            im_req_q  <= 1'b1;
            im_addr_q <= fetch_pc_q;
            state_q   <= IFQ_WAIT;
          end
        end
        IFQ_WAIT: begin
          if (im_ack) begin
            im_req_q <= 1'b0;
            if (redirect) begin
              state_q <= IFQ_IDLE;
            end else begin
              fetch_pc_q <= fetch_pc_q + 1'b1;
              halted_q   <= is_hlt;
              state_q    <= is_hlt ? IFQ_HALTED : IFQ_IDLE;
            end
          end else if (redirect) begin
            state_q <= IFQ_DROP;
          end
        end
        // The memory still owes us the old word; swallow it before reissuing.
        IFQ_DROP: begin
          if (im_ack) begin
            im_req_q <= 1'b0;
            state_q  <= IFQ_IDLE;
          end
        end
        IFQ_HALTED: begin
          if (redirect) state_q <= IFQ_IDLE;
        end
        default: state_q <= IFQ_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_valid = !fifo_empty;
    dec_pc    = '0;
    dec_instr = '0;
    if (bypass) begin
      dec_valid = 1'b1;
      dec_pc    = fetch_pc_q;
      dec_instr = im_instr;
    end else if (!fifo_empty) begin
      dec_pc    = head[E_W-1:INSTR_W];
      dec_instr = head[INSTR_W-1:0];
    end
  end

  assign im_req    = im_req_q;
  assign im_addr   = im_addr_q;
  assign halted    = halted_q;
  assign occupancy = occ;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a latency-programmable memory responder plus scenario tasks.
import wiscsc15_pkg::*;

module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req, im_ack = 1'b0;
  logic [15:0] im_addr, im_instr = 16'h0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [15:0] dec_instr, dec_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halted;
  logic [2:0]  occupancy;

  int vecs = 0;
  int errs = 0;

  int          lat = 1;
  int          wcnt = 0;
  logic        stall = 1'b0;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_pc = 16'h0;

  fetch_entry_t acc[$];
  logic [15:0]  req_addr[$];
  logic         req_prev = 1'b0;
  int           max_occ = 0;

  ifetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_instr    (im_instr),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Memory: acks the lat-th cycle a request has been held; word = 1xxx, or F000 at hlt_pc.
  always @(negedge clk) begin
    if (im_req && !stall) begin
      wcnt   = wcnt + 1;
      im_ack = (wcnt >= lat);
    end else begin
      if (!im_req) wcnt = 0;
      im_ack = 1'b0;
    end
    im_instr = (hlt_en && im_addr == hlt_pc) ? 16'hF000 : {4'h1, im_addr[11:0]};
  end

  always @(posedge clk) begin
    if (dec_valid && dec_ready && !redirect) acc.push_back('{pc: dec_pc, instr: dec_instr});
    if (im_req && !req_prev) req_addr.push_back(im_addr);
    req_prev = im_req;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic redir_on_release, input logic [15:0] rpc);
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; hlt_en = 1'b0; lat = 1;
    tick(); tick();
    acc.delete(); req_addr.delete(); max_occ = 0;
    rst = 1'b0;
    redirect = redir_on_release;
    redirect_pc = rpc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vecs++; if (im_req !== 1'b0) begin errs++; $display("FAIL reset_im_req got %b want 0", im_req); end
    vecs++; if (im_addr !== 16'h0) begin errs++; $display("FAIL reset_im_addr got %h want 0000", im_addr); end
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    vecs++; if (dec_instr !== 16'h0) begin errs++; $display("FAIL reset_dec_instr got %h want 0000", dec_instr); end
    vecs++; if (dec_pc !== 16'h0) begin errs++; $display("FAIL reset_dec_pc got %h want 0000", dec_pc); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b want 0", halted); end
    vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_stream();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b1;
    for (int c = 0; c < 40 && acc.size() < 4; c++) tick();
    vecs++; if (acc.size() < 4) begin errs++; $display("FAIL stream_count got %0d want 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      vecs++; if (req_addr[i] !== 16'(i)) begin errs++; $display("FAIL stream_addr[%0d] got %h want %h", i, req_addr[i], 16'(i)); end
      vecs++; if (acc[i].pc !== 16'(i)) begin errs++; $display("FAIL stream_pc[%0d] got %h want %h", i, acc[i].pc, 16'(i)); end
      vecs++; if (acc[i].instr !== (16'h1000 | 16'(i))) begin errs++; $display("FAIL stream_instr[%0d] got %h want %h", i, acc[i].instr, 16'h1000 | 16'(i)); end
    end
    vecs++; if (max_occ > 1) begin errs++; $display("FAIL stream_max_occ got %0d want <=1", max_occ); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    vecs++; if (occupancy !== 3'd4) begin errs++; $display("FAIL bp_occ got %0d want 4", occupancy); end
    vecs++; if (im_req !== 1'b0) begin errs++; $display("FAIL bp_im_req got %b want 0", im_req); end
    vecs++; if (req_addr.size() != 4) begin errs++; $display("FAIL bp_req_count got %0d want 4", req_addr.size()); end
    vecs++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0 || dec_instr !== 16'h1000) begin
      errs++; $display("FAIL bp_head got v=%b pc=%h i=%h want v=1 pc=0000 i=1000", dec_valid, dec_pc, dec_instr);
    end
    dec_ready = 1'b1;
    for (int c = 0; c < 60 && acc.size() < 5; c++) tick();
    vecs++; if (acc.size() < 5) begin errs++; $display("FAIL bp_drain_count got %0d want 5", acc.size()); end
    for (int i = 0; i < 5 && i < acc.size(); i++) begin
      vecs++; if (acc[i].pc !== 16'(i)) begin errs++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, acc[i].pc, 16'(i)); end
    end
    vecs++; if (req_addr.size() < 5 || req_addr[4] !== 16'h0004) begin errs++; $display("FAIL bp_resume_addr got %0d reqs want 5th at 0004", req_addr.size()); end
  endtask

  task automatic test_redirect_drop();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b1;
    lat = 3;
    for (int c = 0; c < 10 && !im_req; c++) tick();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    vecs++; if (im_req !== 1'b1 || im_addr !== 16'h0000) begin
      errs++; $display("FAIL drop_hold got req=%b addr=%h want req=1 addr=0000", im_req, im_addr);
    end
    for (int c = 0; c < 30 && !dec_valid; c++) tick();
    vecs++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0040 || dec_instr !== 16'h1040) begin
      errs++; $display("FAIL drop_first_valid got v=%b pc=%h i=%h want v=1 pc=0040 i=1040", dec_valid, dec_pc, dec_instr);
    end
    vecs++; if (req_addr.size() != 2 || req_addr[1] !== 16'h0040) begin
      errs++; $display("FAIL drop_reissue got %0d reqs want 2 with 2nd at 0040", req_addr.size());
    end
    lat = 1;
  endtask

  task automatic test_halt();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b1;
    hlt_en = 1'b1; hlt_pc = 16'h0005;
    for (int c = 0; c < 40 && !halted; c++) tick();
    vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_flag got %b want 1", halted); end
    for (int c = 0; c < 10; c++) tick();
    vecs++; if (req_addr.size() != 6) begin errs++; $display("FAIL halt_req_count got %0d want 6", req_addr.size()); end
    vecs++; if (acc.size() != 6 || acc[acc.size()-1].pc !== 16'h0005 || acc[acc.size()-1].instr !== 16'hF000) begin
      errs++; $display("FAIL halt_drain got %0d entries want 6 ending pc=0005 i=F000", acc.size());
    end
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL halt_clear got %b want 0", halted); end
    for (int c = 0; c < 10 && !im_req; c++) tick();
    vecs++; if (im_req !== 1'b1 || im_addr !== 16'h0010) begin
      errs++; $display("FAIL halt_resume got req=%b addr=%h want req=1 addr=0010", im_req, im_addr);
    end
    hlt_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    do_reset(1'b1, 16'hFFFE);
    dec_ready = 1'b1;
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 40 && acc.size() < 4; c++) tick();
    vecs++; if (acc.size() < 4) begin errs++; $display("FAIL wrap_count got %0d want 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      vecs++; if (acc[i].pc !== exp_pc[i]) begin errs++; $display("FAIL wrap_pc[%0d] got %h want %h", i, acc[i].pc, exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b0;
    for (int c = 0; c < 20 && occupancy != 3'd2; c++) tick();
    stall = 1'b1;
    tick();
    vecs++; if (im_req !== 1'b1 || occupancy !== 3'd2) begin
      errs++; $display("FAIL rmid_setup got req=%b occ=%0d want req=1 occ=2", im_req, occupancy);
    end
    rst = 1'b1;
    tick();
    vecs++; if (im_req !== 1'b0 || dec_valid !== 1'b0 || occupancy !== 3'd0 || im_addr !== 16'h0) begin
      errs++; $display("FAIL rmid_state got req=%b v=%b occ=%0d addr=%h want 0 0 0 0000", im_req, dec_valid, occupancy, im_addr);
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_ack_latency();
    do_reset(1'b0, 16'h0);
    dec_ready = 1'b1;
    lat = 2;
    for (int c = 0; c < 20 && !im_ack; c++) tick();
`ifdef IFQ_BYPASS_EN
    vecs++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0 || dec_instr !== 16'h1000) begin
      errs++; $display("FAIL lat_bypass got v=%b pc=%h i=%h want v=1 pc=0000 i=1000", dec_valid, dec_pc, dec_instr);
    end
    tick();
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL lat_after_bypass got %b want 0", dec_valid); end
`else
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL lat_ack_cycle got %b want 0", dec_valid); end
    tick();
    vecs++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0 || dec_instr !== 16'h1000) begin
      errs++; $display("FAIL lat_next_cycle got v=%b pc=%h i=%h want v=1 pc=0000 i=1000", dec_valid, dec_pc, dec_instr);
    end
`endif
    lat = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_ack_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage for the WISC-SC15 core. It sits between the instruction memory and the decode/control datapath.
- Owns the fetch PC and issues one request at a time to an instruction memory that may stall.
- Buffers returned instructions, each with its PC, in a small FIFO.
- Delivers them to decode with a valid/ready handshake.
- Supports a redirect input for branches, calls and returns, and stops fetching after an HLT instruction.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, at least 2)
ADDR_W, 16, fetch address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, fetch PC after reset

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-high
im_req  out  1  instruction memory request
im_addr  out  ADDR_W  request address
im_ack  in  1  request completes this cycle; im_instr is valid
im_instr  in  INSTR_W  returned instruction word
dec_valid  out  1  head entry is valid for decode
dec_instr  out  INSTR_W  head instruction
dec_pc  out  ADDR_W  PC of the head instruction
dec_ready  in  1  decode accepts the head entry this cycle
redirect  in  1  flush the queue and restart fetch
redirect_pc  in  ADDR_W  new fetch PC
halted  out  1  fetch stopped after an HLT
occupancy  out  log2(DEPTH)+1  current FIFO entry count

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous, active-high.
- On rst: state IDLE, fetch_pc=RESET_PC, FIFO empty.
- Reset values: im_req=0, im_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, halted=0, occupancy=0.
- rst asserted mid-request abandons that request. The memory must tolerate a dropped im_req.

FSM states: IDLE, WAIT, DROP, HALTED.
- IDLE:
  - If occupancy + (1 if a pop occurs this cycle) < DEPTH, and redirect=0: assert im_req, latch im_addr=fetch_pc, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - im_req stays high and im_addr stays stable until im_ack.
  - On im_ack: push {fetch_pc, im_instr}; fetch_pc <= fetch_pc+1 (wraps 16'hFFFF to 0); drop im_req; go to IDLE.
  - If the pushed instruction has im_instr[15:12]==HLT_OPCODE (4'hF), go to HALTED instead of IDLE.
- DROP:
  - Entered when redirect occurs in WAIT without a same-cycle im_ack.
  - im_req stays high at the old address. On im_ack, discard the data and go to IDLE.
- HALTED:
  - im_req=0, halted=1. The FIFO continues to drain to decode.
  - Leave only on redirect (to IDLE) or rst.

Redirect (priority over push, pop and halt in the same cycle):
- FIFO cleared; dec_valid=0 the next cycle.
- fetch_pc <= redirect_pc; halted clears.
- In WAIT with im_ack the same cycle: returned data is discarded, next state IDLE.
- In WAIT without im_ack: next state DROP, and fetch_pc still takes redirect_pc.
- A redirect while in DROP only updates fetch_pc.

Issue rule and FIFO:
- At most one outstanding request.
- A request is issued only when its eventual push cannot overflow: occupancy + outstanding < DEPTH. A push into a full FIFO therefore cannot occur.
- Pop when dec_valid && dec_ready. Push and pop in the same cycle is legal; occupancy is unchanged.
- Default latency: data returned on im_ack appears on dec_* the next cycle (registered FIFO head).
- dec_instr and dec_pc must not change while dec_valid=1 and dec_ready=0.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, im_ack=1 and no redirect, im_instr/fetch_pc drive dec_* combinationally with dec_valid=1 in the same cycle.
  - If dec_ready=1, the entry is not written to the FIFO.
  - If dec_ready=0, it is pushed normally.
- Undefined: no bypass; minimum ack-to-dec_valid latency is 1 cycle.

Decomposition:
- Shared package wiscsc15_pkg holds:
  - HLT_OPCODE=4'hF
  - FSM state encodings IFQ_IDLE, IFQ_WAIT, IFQ_DROP, IFQ_HALTED
  - ADDR_W/INSTR_W defaults
  - a fetch-entry struct {pc, instr}
- One natural sub-module: ifq_fifo, a synchronous FIFO with parameter DEPTH and ports push, pop, clear, occupancy, full and empty.
- The FSM, fetch PC and issue logic stay in ifetch_queue.

Test Plan:
1. Reset, then memory acks every cycle, dec_ready=1 → im_addr sequence 0,1,2,3; dec_pc 0,1,2,3 with matching instructions; occupancy never exceeds 1.
2. dec_ready=0 with immediate acks → exactly 4 entries (pc 0..3); im_req then stays 0. Raise dec_ready → entries drain in order and fetch resumes at 4.
3. Memory acks after 3 cycles; redirect to 16'h0040 on the 2nd wait cycle → im_addr held at the old PC until ack; that data is discarded; next request address is 16'h0040; dec_valid stays 0 until the 16'h0040 entry arrives.
4. Instruction 16'hF000 returned at pc 5 → halted=1; no further im_req; the queue drains through pc 5. Redirect to 16'h0010 → halted=0 and fetch resumes at 16'h0010.
5. redirect_pc=16'hFFFE, free-running acks → PCs FFFE, FFFF, 0000, 0001.
6. rst asserted while in WAIT with 2 queued entries → next cycle: im_req=0, dec_valid=0, occupancy=0, im_addr=RESET_PC. With IFQ_BYPASS_EN, empty queue and dec_ready=1 → dec_valid coincides with im_ack.
